// File: rtl/lycan_globals.sv
// ============================================================================
//  Module      : lycan_globals
//  Description : Shared constants and packet helpers for the Lycan USB bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lycan_globals;

    localparam int c_usb_packet_width = 32;
    localparam int c_num_peripherals  = 8;
    localparam int c_periph_addr_msb  = 31;
    localparam int c_periph_addr_w    = $clog2(c_num_peripherals);

    // Target peripheral index carried in the top bits of every host packet.
    function automatic logic [c_periph_addr_w-1:0] get_periph_addr(
        input logic [c_usb_packet_width-1:0] packet
    );
        return packet[c_periph_addr_msb -: c_periph_addr_w];
    endfunction

endpackage

`default_nettype wire

// File: rtl/periph_dispatcher_decoder.sv
// ============================================================================
//  Module      : periph_dispatcher_decoder
//  Description : Binary-to-one-hot decoder, all outputs low when not valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_dispatcher_decoder #(
    parameter int WIDTH = 8
) (
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] i_sel,
    input  logic                                         i_valid,
    output logic [WIDTH-1:0]                             o_onehot
);

    localparam int c_sel_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign o_onehot[i] = i_valid & (i_sel == c_sel_w'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/periph_dispatcher.sv
// ============================================================================
//  Module      : periph_dispatcher
//  Description : Routes host packets from the FTDI FIFO to one peripheral tx
//                port each, with backpressure, enable masking and stall drop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_dispatcher
    import lycan_globals::*;
#(
    parameter int NUM_PERIPH    = c_num_peripherals,
    parameter int WIDTH         = c_usb_packet_width,
    parameter int ADDR_MSB      = c_periph_addr_msb,
    parameter int STALL_TIMEOUT = 1024,
    parameter int DROP_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_PERIPH-1:0] periph_enable,
    input  logic [NUM_PERIPH-1:0] periph_tx_full,
    output logic [WIDTH-1:0]      periph_tx_data,
    output logic [NUM_PERIPH-1:0] periph_tx_valid,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);

    localparam int c_addr_w  = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam int c_addr_w1 = c_addr_w + 1;
    localparam int c_tmr_w   = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam bit c_drop_en = (STALL_TIMEOUT != 0);

    localparam logic [c_addr_w:0]  c_num_periph = c_addr_w1'(NUM_PERIPH);
    localparam logic [c_tmr_w-1:0] c_tmr_last   =
        c_tmr_w'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

    logic [0:0]            r_state;
    logic [WIDTH-1:0]      r_hold_data;
    logic [c_addr_w-1:0]   r_hold_addr;
    logic [c_tmr_w-1:0]    r_timer;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic w_hold_valid;
    logic w_addr_ok;
    logic w_en_ok;
    logic w_full;
    logic w_deliver;
    logic w_stall;
    logic w_drop;
    logic w_leave;
    logic w_in_ready;
    logic w_accept;

    assign w_hold_valid = (r_state == c_st_hold);
    assign w_addr_ok    = ({1'b0, r_hold_addr} < c_num_periph);
    assign w_en_ok      = w_addr_ok && periph_enable[r_hold_addr];
    assign w_full       = periph_tx_full[r_hold_addr];

    // Disabled/out-of-range targets are dropped before fullness is considered.
    assign w_deliver  = w_hold_valid & w_en_ok & ~w_full;
    assign w_stall    = w_hold_valid & w_en_ok &  w_full;
    assign w_drop     = (w_hold_valid & ~w_en_ok)
                      | (w_stall & c_drop_en & (r_timer == c_tmr_last));
    assign w_leave    = w_deliver | w_drop;

    // Refill in the same cycle the held packet leaves, so no bubble.
    assign w_in_ready = rst_l & (~w_hold_valid | w_leave);
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= c_st_empty;
            r_hold_data <= '0;
            r_hold_addr <= '0;
            r_timer     <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end

            if (w_accept) begin
                r_state     <= c_st_hold;
                r_hold_data <= in_data;
                r_hold_addr <= in_data[ADDR_MSB -: c_addr_w];
                r_timer     <= '0;
            end else if (w_leave) begin
                r_state     <= c_st_empty;
                r_timer     <= '0;
            end else if (w_stall && c_drop_en) begin
                r_timer     <= r_timer + c_tmr_w'(1);
            end
        end
    end

    periph_dispatcher_decoder #(
        .WIDTH    (NUM_PERIPH)
    ) u_decoder (
        .i_sel    (r_hold_addr),
        .i_valid  (w_deliver),
        .o_onehot (periph_tx_valid)
    );

    assign in_ready       = w_in_ready;
    assign periph_tx_data = r_hold_data;
    assign drop_pulse     = w_drop;
    assign drop_count     = r_drop_cnt;
    assign busy           = w_hold_valid;

endmodule

`default_nettype wire

// File: tb/tb_periph_dispatcher.sv
// ============================================================================
//  Module      : tb_periph_dispatcher
//  Description : Directed and random self-checking bench for periph_dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_dispatcher;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  periph_enable = 8'hFF;
    logic [7:0]  periph_tx_full = 8'h00;
    logic [31:0] periph_tx_data;
    logic [7:0]  periph_tx_valid;
    logic        drop_pulse;
    logic [3:0]  drop_count;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    periph_dispatcher #(
        .NUM_PERIPH     (8),
        .WIDTH          (32),
        .ADDR_MSB       (31),
        .STALL_TIMEOUT  (16),
        .DROP_CNT_W     (4)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .periph_enable   (periph_enable),
        .periph_tx_full  (periph_tx_full),
        .periph_tx_data  (periph_tx_data),
        .periph_tx_valid (periph_tx_valid),
        .drop_pulse      (drop_pulse),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycle-level reference: one holding slot, drop beats deliver beats stall.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [2:0]  m_addr  = '0;
    int          m_timer = 0;
    logic [3:0]  m_cnt   = '0;
    logic [7:0]  e_tx    = '0;
    logic        e_drop  = 1'b0;
    logic        e_rdy   = 1'b0;
    logic        sb_on   = 1'b0;
    int          n_acc = 0, n_del = 0, n_drp = 0;

    always @(negedge clk) begin
        if (rst_l) begin
            e_tx   = '0;
            e_drop = 1'b0;
            if (m_valid) begin
                if (!periph_enable[m_addr])      e_drop = 1'b1;
                else if (!periph_tx_full[m_addr]) e_tx  = 8'(1) << m_addr;
                else if (m_timer == 15)           e_drop = 1'b1;
            end
            e_rdy = !m_valid || (e_tx != 0) || e_drop;
            chk("m_tx_valid", periph_tx_valid, e_tx);
            chk("m_drop", drop_pulse, e_drop);
            chk("m_in_ready", in_ready, e_rdy);
            chk("m_busy", busy, m_valid);
            chk("m_count", drop_count, m_cnt);
            if (m_valid) chk("m_data", periph_tx_data, m_data);
            chk("onehot0", $onehot0(periph_tx_valid), 1);
            chk("tx_to_full", |(periph_tx_valid & periph_tx_full), 0);
            if (sb_on) begin
                if (in_valid && in_ready) n_acc++;
                if (|periph_tx_valid)     n_del++;
                if (drop_pulse)           n_drp++;
            end
        end else begin
            e_tx   = '0;
            e_drop = 1'b0;
            e_rdy  = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_addr  = '0;
            m_timer = 0;
            m_cnt   = '0;
        end else begin
            if (e_drop && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (in_valid && e_rdy) begin
                m_valid = 1'b1;
                m_data  = in_data;
                m_addr  = in_data[31:29];
                m_timer = 0;
            end else if ((e_tx != 0) || e_drop) begin
                m_valid = 1'b0;
                m_timer = 0;
            end else if (m_valid) begin
                m_timer++;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", periph_tx_valid, 0);
        chk("rst_tx_data", periph_tx_data, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_count", drop_count, 0);
        cyc();
        rst_l = 1'b1;

        // Reset while holding discards the packet
        periph_tx_full = 8'hFF;
        in_valid = 1'b1;
        in_data  = 32'h6000_0011;
        @(negedge clk);
        chk("t1_rdy", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_stall", periph_tx_valid, 0);
        #1 rst_l = 1'b0;
        #1;
        chk("t1_busy_rst", busy, 0);
        chk("t1_rdy_rst", in_ready, 0);
        chk("t1_data_rst", periph_tx_data, 0);
        chk("t1_tx_rst", periph_tx_valid, 0);
        periph_tx_full = 8'h00;
        #1;
        chk("t1_tx_rst_free", periph_tx_valid, 0);
        repeat (2) cyc();
        rst_l = 1'b1;
        @(negedge clk);
        chk("t1_tx_after", periph_tx_valid, 0);
        chk("t1_busy_after", busy, 0);

        // Back-to-back stream
        cyc();
        in_valid = 1'b1;
        in_data  = 32'h2000_0001;
        @(negedge clk);
        chk("t2_rdy0", in_ready, 1);
        chk("t2_tx0", periph_tx_valid, 8'h00);
        cyc();
        in_data = 32'h4000_0002;
        @(negedge clk);
        chk("t2_tx1", periph_tx_valid, 8'h02);
        chk("t2_d1", periph_tx_data, 32'h2000_0001);
        chk("t2_rdy1", in_ready, 1);
        cyc();
        in_data = 32'hE000_0003;
        @(negedge clk);
        chk("t2_tx2", periph_tx_valid, 8'h04);
        chk("t2_d2", periph_tx_data, 32'h4000_0002);
        chk("t2_rdy2", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_tx3", periph_tx_valid, 8'h80);
        chk("t2_d3", periph_tx_data, 32'hE000_0003);
        cyc();
        @(negedge clk);
        chk("t2_idle", busy, 0);

        // Backpressure on port 3
        cyc();
        periph_tx_full = 8'h08;
        in_valid = 1'b1;
        in_data  = 32'h6000_00AA;
        @(negedge clk);
        chk("t3_rdy_acc", in_ready, 1);
        cyc();
        in_data = 32'h2000_0BBB;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_rdy_stall", in_ready, 0);
            chk("t3_tx_stall", periph_tx_valid, 0);
            cyc();
        end
        periph_tx_full = 8'h00;
        @(negedge clk);
        chk("t3_tx_rel", periph_tx_valid, 8'h08);
        chk("t3_d_rel", periph_tx_data, 32'h6000_00AA);
        chk("t3_rdy_rel", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_tx_next", periph_tx_valid, 8'h02);
        chk("t3_d_next", periph_tx_data, 32'h2000_0BBB);
        cyc();
        @(negedge clk);
        chk("t3_idle", busy, 0);

        // Stall timeout on port 5
        cyc();
        periph_tx_full = 8'h20;
        in_valid = 1'b1;
        in_data  = 32'hA000_0000;
        cyc();
        in_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("t4_no_drop", drop_pulse, 0);
            chk("t4_no_tx", periph_tx_valid, 0);
            cyc();
        end
        @(negedge clk);
        chk("t4_drop", drop_pulse, 1);
        chk("t4_tx", periph_tx_valid, 0);
        chk("t4_rdy", in_ready, 1);
        cyc();
        periph_tx_full = 8'h00;
        @(negedge clk);
        chk("t4_count", drop_count, 1);
        chk("t4_idle", busy, 0);

        // Disabled port 1, then saturation
        cyc();
        periph_enable = 8'hFD;
        in_valid = 1'b1;
        in_data  = 32'h2000_0055;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_drop", drop_pulse, 1);
        chk("t5_tx", periph_tx_valid, 0);
        chk("t5_rdy", in_ready, 1);
        cyc();
        @(negedge clk);
        chk("t5_count", drop_count, 2);
        cyc();
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 32'h2000_0100 + 32'(k);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_sat_pulse", drop_pulse, 1);
        chk("t5_sat_cnt", drop_count, 15);
        cyc();
        @(negedge clk);
        chk("t5_sat_final", drop_count, 15);
        chk("t5_idle", busy, 0);

        // Enable removed while stalled on port 4
        cyc();
        periph_enable  = 8'hFF;
        periph_tx_full = 8'h10;
        in_valid = 1'b1;
        in_data  = 32'h8000_0001;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5b_stall", drop_pulse, 0);
            cyc();
        end
        periph_enable = 8'hEF;
        @(negedge clk);
        chk("t5b_drop", drop_pulse, 1);
        chk("t5b_tx", periph_tx_valid, 0);
        cyc();
        periph_enable  = 8'hFF;
        periph_tx_full = 8'h00;
        @(negedge clk);
        chk("t5b_idle", busy, 0);

        // Random traffic against the reference
        sb_on = 1'b1;
        for (int k = 0; k < 400; k++) begin
            cyc();
            in_valid       = ($urandom_range(0, 3) != 0);
            in_data        = {3'($urandom_range(0, 7)), 29'($urandom)};
            periph_tx_full = 8'($urandom) & 8'($urandom);
            periph_enable  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
        end
        cyc();
        in_valid       = 1'b0;
        periph_tx_full = 8'h00;
        periph_enable  = 8'hFF;
        repeat (5) cyc();
        sb_on = 1'b0;
        @(negedge clk);
        chk("t6_conserve", n_del + n_drp, n_acc);
        chk("t6_traffic", (n_del > 50), 1);
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
